// File: rtl/md_iter_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage of the 5-stage MIPS core.
// The result is computed when the op is launched, held for a fixed latency, and then committed.
module md_iter_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        a1,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        we,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] stage_hi, stage_lo;
  logic        stage_ok;
  logic        launch, commit;

  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b, abs_a, abs_b, uq, ur;
  logic [31:0] res_hi, res_lo;
  logic        sgn, res_ok;

  // mode[1] selects divide, mode[0] selects unsigned
  always_comb begin
    sgn    = ~mode[0];
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'b0, a} * {32'b0, b};
    div_b  = (b == 32'b0) ? 32'd1 : b;
    // Divide on magnitudes so 0x80000000 / -1 wraps instead of overflowing
    abs_a  = (sgn && a[31])     ? -a     : a;
    abs_b  = (sgn && div_b[31]) ? -div_b : div_b;
    uq     = abs_a / abs_b;
    ur     = abs_a % abs_b;
    res_ok = !(mode[1] && (b == 32'b0));
    if (mode[1]) begin
      res_lo = (sgn && (a[31] ^ b[31])) ? -uq : uq;
      res_hi = (sgn && a[31])           ? -ur : ur;
    end else begin
      res_lo = sgn ? prod_s[31:0]  : prod_u[31:0];
      res_hi = sgn ? prod_s[63:32] : prod_u[63:32];
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: if (start) begin
        launch    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (cnt == 4'd1) begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      stage_hi <= 32'b0;
      stage_lo <= 32'b0;
      stage_ok <= 1'b0;
      hi       <= 32'b0;
      lo       <= 32'b0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        cnt      <= mode[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        stage_hi <= res_hi;
        stage_lo <= res_lo;
        stage_ok <= res_ok;
      end else if (state == RUN) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        if (stage_ok) begin
          hi <= stage_hi;
          lo <= stage_lo;
        end
      end else if (state == IDLE && !start && we) begin
        if (a1) lo <= a;
        else    hi <= a;
      end
    end
  end

endmodule
